// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline: data RAM with word/halfword
// stores, write-back select, sticky halt flag and load/store event counters.
module mem_stage #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              MemToReg,
  input  logic              MemWrite,
  input  logic              sh,
  input  logic              jal,
  input  logic              halt,
  input  logic              RegWrite,
  input  logic [4:0]        RW,
  input  logic [31:0]       p,
  input  logic [31:0]       R,
  input  logic [31:0]       B,
  output logic [31:0]       wb_data,
  output logic              wb_RegWrite,
  output logic [4:0]        wb_RW,
  output logic              halted,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]       ram [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rd_word;
  logic [31:0]       wr_word;
  logic              active;
  logic              wr_en;
  logic              load_ev;
  logic              store_ev;
  logic              unused_addr_bits;

  // Upper address bits wrap away; byte offset only matters for halfword select.
  assign word_idx         = R[ADDR_W+1:2];
  assign unused_addr_bits = ^{R[31:ADDR_W+2], R[0]};

  assign rd_word  = ram[word_idx];
  assign dbg_data = ram[dbg_addr];

  // An instruction only takes effect when the stage is advancing and not halted.
  assign active   = ~pause & ~halted & ~rst;
  assign wr_en    = active & MemWrite & ~halt;
  assign load_ev  = active & MemToReg;
  assign store_ev = wr_en;

  always_comb begin
    wr_word = B;
    if (sh) begin
      if (R[1])
        wr_word = {B[15:0], rd_word[15:0]};
      else
        wr_word = {rd_word[31:16], B[15:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      ram[word_idx] <= wr_word;
  end

  always_comb begin
    wb_data = R;
    if (jal)
      wb_data = p;
    else if (MemToReg)
      wb_data = rd_word;
  end

  assign wb_RW       = RW;
  assign wb_RegWrite = RegWrite & ~halted;

  always_ff @(posedge clk) begin
    if (rst)
      halted <= 1'b0;
    else if (halt && !pause)
      halted <= 1'b1;
  end

  // Counters saturate so the display never wraps back to a small number.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      if (load_ev && load_cnt != CNT_MAX)
        load_cnt <= load_cnt + CNT_ONE;
      if (store_ev && store_cnt != CNT_MAX)
        store_cnt <= store_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: table-driven write-back mux vectors plus
// hand-written sequences for stores, stalls, halt, saturation and reset.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        pause;
  logic        MemToReg;
  logic        MemWrite;
  logic        sh;
  logic        jal;
  logic        halt;
  logic        RegWrite;
  logic [4:0]  RW;
  logic [31:0] p;
  logic [31:0] R;
  logic [31:0] B;
  logic [31:0] wb_data;
  logic        wb_RegWrite;
  logic [4:0]  wb_RW;
  logic        halted;
  logic [15:0] load_cnt;
  logic [15:0] store_cnt;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_data;

  int compared;
  int mismatched;

  typedef struct {
    logic        jal;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  rw;
    logic [31:0] p;
    logic [31:0] r;
    logic [31:0] exp_wb_data;
    logic        exp_reg_write;
  } vec_t;

  vec_t vecs [7];

  mem_stage #(.ADDR_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pause(pause), .MemToReg(MemToReg),
    .MemWrite(MemWrite), .sh(sh), .jal(jal), .halt(halt),
    .RegWrite(RegWrite), .RW(RW), .p(p), .R(R), .B(B),
    .wb_data(wb_data), .wb_RegWrite(wb_RegWrite), .wb_RW(wb_RW),
    .halted(halted), .load_cnt(load_cnt), .store_cnt(store_cnt),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One clock edge with the current inputs, then settle just after it.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearInputs();
    pause = 0; MemToReg = 0; MemWrite = 0; sh = 0; jal = 0; halt = 0;
    RegWrite = 0; RW = 0; p = 0; R = 0; B = 0; dbg_addr = 0;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    clearInputs();
    rst = 1;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 5'd31, 32'h0040_0008, 32'h0000_0010, 32'h0040_0008, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 5'd5,  32'h0040_0008, 32'h0000_0055, 32'h0000_0055, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 5'd9,  32'h0000_0000, 32'h0000_0010, 32'h5678_ABCD, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 5'd10, 32'h0000_0000, 32'h0000_0013, 32'h5678_ABCD, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 5'd11, 32'h0000_0000, 32'h0000_1010, 32'h5678_ABCD, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 5'd12, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_0000, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1};

    applyStimulus(2);
    rst = 0;
    checkOutput("reset_halted", {31'b0, halted}, 32'h0);
    checkOutput("reset_load_cnt", {16'b0, load_cnt}, 32'h0);
    checkOutput("reset_store_cnt", {16'b0, store_cnt}, 32'h0);

    // Word store then load of the same address on the next cycle
    MemWrite = 1; R = 32'h10; B = 32'hDEAD_BEEF;
    applyStimulus(1);
    MemWrite = 0; MemToReg = 1;
    #1;
    checkOutput("load_after_store", wb_data, 32'hDEAD_BEEF);
    checkOutput("store_cnt_1", {16'b0, store_cnt}, 32'd1);
    applyStimulus(1);
    MemToReg = 0;
    checkOutput("load_cnt_1", {16'b0, load_cnt}, 32'd1);
    dbg_addr = 10'd4;
    #1;
    checkOutput("dbg_word_store", dbg_data, 32'hDEAD_BEEF);

    // Halfword stores into upper then lower half
    MemWrite = 1; sh = 1; R = 32'h12; B = 32'h0000_1234;
    applyStimulus(1);
    checkOutput("half_upper", dbg_data, 32'h1234_BEEF);
    R = 32'h10; B = 32'h0000_ABCD;
    applyStimulus(1);
    checkOutput("half_lower", dbg_data, 32'h1234_ABCD);
    R = 32'h12; B = 32'hFFFF_5678;
    applyStimulus(1);
    MemWrite = 0; sh = 0;
    checkOutput("half_upper_bits_ignored", dbg_data, 32'h5678_ABCD);
    checkOutput("store_cnt_4", {16'b0, store_cnt}, 32'd4);

    // Write-back mux table, held under pause so no state changes
    pause = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      jal = vecs[i].jal; MemToReg = vecs[i].mem_to_reg;
      RegWrite = vecs[i].reg_write; RW = vecs[i].rw;
      p = vecs[i].p; R = vecs[i].r;
      #1;
      checkOutput($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].exp_wb_data);
      checkOutput($sformatf("vec%0d_wb_RegWrite", i), {31'b0, wb_RegWrite},
                  {31'b0, vecs[i].exp_reg_write});
      checkOutput($sformatf("vec%0d_wb_RW", i), {27'b0, wb_RW}, {27'b0, vecs[i].rw});
    end
    applyStimulus(1);
    checkOutput("pause_load_cnt_held", {16'b0, load_cnt}, 32'd1);
    clearInputs();
    dbg_addr = 10'd4;

    // Stalled store commits once, and address 0x1000 wraps to word 0
    MemWrite = 1; R = 32'h0; B = 32'h1111_1111;
    applyStimulus(1);
    dbg_addr = 10'd0;
    R = 32'h1000; B = 32'hA5A5_A5A5; pause = 1;
    applyStimulus(3);
    checkOutput("paused_no_write", dbg_data, 32'h1111_1111);
    checkOutput("paused_store_cnt", {16'b0, store_cnt}, 32'd5);
    pause = 0;
    applyStimulus(1);
    MemWrite = 0;
    checkOutput("wrap_write_word0", dbg_data, 32'hA5A5_A5A5);
    checkOutput("store_cnt_once", {16'b0, store_cnt}, 32'd6);

    // Load counter saturates at all-ones
    MemToReg = 1; R = 32'h0;
    applyStimulus(65540);
    MemToReg = 0;
    checkOutput("load_cnt_saturated", {16'b0, load_cnt}, 32'h0000_FFFF);

    // Halt is sticky and blocks later stores and write-back enables
    halt = 1;
    applyStimulus(1);
    halt = 0;
    checkOutput("halted_set", {31'b0, halted}, 32'h1);
    RegWrite = 1;
    #1;
    checkOutput("halted_regwrite_gated", {31'b0, wb_RegWrite}, 32'h0);
    MemWrite = 1; R = 32'h10; B = 32'hFFFF_FFFF; dbg_addr = 10'd4;
    applyStimulus(2);
    MemWrite = 0; RegWrite = 0;
    checkOutput("halted_no_write", dbg_data, 32'h5678_ABCD);
    checkOutput("halted_store_cnt_frozen", {16'b0, store_cnt}, 32'd6);
    checkOutput("halted_sticky", {31'b0, halted}, 32'h1);

    // Reset clears state, overrides a simultaneous store, keeps RAM
    rst = 1; MemWrite = 1; R = 32'h10; B = 32'hFFFF_FFFF;
    applyStimulus(1);
    rst = 0; MemWrite = 0;
    checkOutput("rst_halted", {31'b0, halted}, 32'h0);
    checkOutput("rst_load_cnt", {16'b0, load_cnt}, 32'h0);
    checkOutput("rst_store_cnt", {16'b0, store_cnt}, 32'h0);
    checkOutput("rst_ram_kept", dbg_data, 32'h5678_ABCD);

    // Halt and store in the same cycle: halt wins
    halt = 1; MemWrite = 1; R = 32'h10; B = 32'h0BAD_F00D;
    applyStimulus(1);
    halt = 0; MemWrite = 0;
    checkOutput("halt_store_same_cycle", dbg_data, 32'h5678_ABCD);
    checkOutput("halt_same_cycle_set", {31'b0, halted}, 32'h1);

    // Reset asserted during a stall still clears state
    rst = 1;
    applyStimulus(1);
    rst = 0;
    MemToReg = 1;
    applyStimulus(1);
    checkOutput("load_cnt_after_rst", {16'b0, load_cnt}, 32'd1);
    pause = 1; rst = 1; halt = 1;
    applyStimulus(1);
    rst = 0; halt = 0; MemToReg = 0; pause = 0;
    checkOutput("rst_mid_stall_load_cnt", {16'b0, load_cnt}, 32'h0);
    checkOutput("rst_mid_stall_halted", {31'b0, halted}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Holds the data RAM. Performs word stores, halfword stores and word loads.
- Selects the write-back value (memory data, ALU result or link address) and keeps a sticky halt flag plus load/store event counters for the FPGA display.
- Also exposes a second, read-only debug port into the RAM for the board's memory viewer.

Parameters:
- ADDR_W, 10, word-address width; RAM holds 2^ADDR_W 32-bit words.
- CNT_W, 16, width of the load/store event counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pause  in  1  pipeline stall; same signal that freezes EX/MEM
- MemToReg  in  1  load: write-back takes memory data
- MemWrite  in  1  store enable
- sh  in  1  store is halfword (valid only with MemWrite)
- jal  in  1  write-back takes link address
- halt  in  1  syscall-halt instruction in this stage
- RegWrite  in  1  instruction writes the register file
- RW  in  5  destination register
- p  in  32  PC+4 of the instruction (link value)
- R  in  32  ALU result, used as byte address
- B  in  32  store data
- wb_data  out  32  value to MEM/WB and to the forwarding mux
- wb_RegWrite  out  1  RegWrite, gated as described below
- wb_RW  out  5  RW pass-through
- halted  out  1  sticky halt flag
- load_cnt  out  CNT_W  number of executed loads
- store_cnt  out  CNT_W  number of executed stores
- dbg_addr  in  ADDR_W  debug word address
- dbg_data  out  32  RAM word at dbg_addr, asynchronous read

Behaviour:
- Word index is R[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo RAM size. R[1:0] are ignored for word accesses.
- RAM reads are asynchronous, both for the load path and for dbg_data. RAM writes are synchronous on the posedge.
- A write commits on the posedge when MemWrite=1, pause=0, halted=0 and rst=0.
- Word store (sh=0): the full word becomes B.
- Halfword store (sh=1):
  - R[1]=0 → bits 15:0 become B[15:0].
  - R[1]=1 → bits 31:16 become B[15:0].
  - The other half of the word is preserved.
- wb_data is combinational. Priority: jal → p; else MemToReg → RAM word; else R.
- A load issued the cycle after a store to the same address returns the new data.
- wb_RW = RW. wb_RegWrite = RegWrite & ~halted.
- Halt flag:
  - halted is set on the posedge when halt=1 and pause=0.
  - It stays 1 until rst.
  - While halted, stores are suppressed and counters freeze.
  - A store in the same cycle as halt is suppressed; halt has priority.
- Counters:
  - load_cnt increments on a posedge with MemToReg=1, pause=0, halted=0.
  - store_cnt increments on a posedge with MemWrite=1, pause=0, halted=0.
  - Both saturate at all-ones; no wrap.
  - pause=1 holds both counters, so a stalled instruction is counted once.
- Reset:
  - rst clears halted, load_cnt and store_cnt to 0.
  - RAM contents are NOT cleared by rst. RAM is zero at power-up only.
  - rst overrides a simultaneous store or halt; no write occurs that cycle.
  - rst asserted mid-stall clears state regardless of pause.
- Combinational outputs (wb_data, wb_RegWrite, wb_RW, dbg_data) have no reset value; they follow their inputs and the RAM.

Test Plan:
1. Word store then load: store R=0x10, B=0xDEADBEEF, MemWrite=1. Next cycle MemToReg=1, R=0x10 → wb_data=0xDEADBEEF, store_cnt=1, load_cnt=1.
2. Halfword store over that word: sh=1, R=0x12, B=0x00001234 → word at 0x10 reads 0x1234BEEF. Then R=0x10, B=0x0000ABCD → word reads 0x1234ABCD.
3. Mux priority: jal=1, MemToReg=1, p=0x00400008, R=0x10 → wb_data=0x00400008. With jal=0, MemToReg=0, R=0x55 → wb_data=0x55.
4. Pause: MemWrite=1, pause=1 held 3 cycles, then pause=0 → RAM written once, store_cnt increments by exactly 1. Address wrap: R=0x1000 with ADDR_W=10 hits word 0.
5. Halt: halt=1 → halted=1 next edge. A later store of 0xFFFFFFFF is not committed, counters frozen, wb_RegWrite=0 with RegWrite=1. halt and MemWrite in the same cycle → no write.
6. Reset: rst=1 with halted=1, counters non-zero and MemWrite=1 → halted=0 and counters=0 after the edge. RAM keeps its prior contents, and the store attempted during rst is not committed; check via dbg_addr.
